// File: rtl/arm_pkg.sv
// Shared ARM core encodings: opcodes, EXE commands, modes, condition codes, status bit positions.
// Pure definitions plus a condition evaluator; no state, no latency, no flow control.
package arm_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       s;
        logic       b;
        logic       mem_w_en;
        logic       mem_r_en;
        logic       wb_en;
    } ctrl_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] st);
        logic n, z, c, v;
        n = st[ST_N];
        z = st[ST_Z];
        c = st[ST_C];
        v = st[ST_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Decode-stage bundle: IF/ID inputs, WB port, EXE/MEM producer info and the ID/EX outputs.
// master drives the stage inputs and observes results; slave is the decode stage itself.
interface id_stage_pipelined_if #(
    parameter int N    = 32,
    parameter int RA_W = 4
);
    logic [N-1:0]    pc_in;
    logic [31:0]     instr_in;
    logic            freeze_in;
    logic            flush_in;
    logic            wb_en_in;
    logic [RA_W-1:0] wb_dest_in;
    logic [N-1:0]    wb_value_in;
    logic [3:0]      status_in;
    logic            exe_wb_en_in;
    logic [RA_W-1:0] exe_dest_in;
    logic            exe_s_in;
    logic            mem_wb_en_in;
    logic [RA_W-1:0] mem_dest_in;

    logic            hazard_out;
    logic [N-1:0]    pc_out;
    logic [N-1:0]    val_rn_out;
    logic [N-1:0]    val_rm_out;
    logic [3:0]      exe_cmd_out;
    logic            s_out;
    logic            b_out;
    logic            mem_w_en_out;
    logic            mem_r_en_out;
    logic            wb_en_out;
    logic            i_out;
    logic            valid_out;
    logic [RA_W-1:0] dest_out;
    logic [RA_W-1:0] rn_out;
    logic [RA_W-1:0] src2_out;
    logic [11:0]     shift_operand_out;
    logic [23:0]     imm_out;

    modport master (
        output pc_in, instr_in, freeze_in, flush_in, wb_en_in, wb_dest_in, wb_value_in,
               status_in, exe_wb_en_in, exe_dest_in, exe_s_in, mem_wb_en_in, mem_dest_in,
        input  hazard_out, pc_out, val_rn_out, val_rm_out, exe_cmd_out, s_out, b_out,
               mem_w_en_out, mem_r_en_out, wb_en_out, i_out, valid_out, dest_out, rn_out,
               src2_out, shift_operand_out, imm_out
    );

    modport slave (
        input  pc_in, instr_in, freeze_in, flush_in, wb_en_in, wb_dest_in, wb_value_in,
               status_in, exe_wb_en_in, exe_dest_in, exe_s_in, mem_wb_en_in, mem_dest_in,
        output hazard_out, pc_out, val_rn_out, val_rm_out, exe_cmd_out, s_out, b_out,
               mem_w_en_out, mem_r_en_out, wb_en_out, i_out, valid_out, dest_out, rn_out,
               src2_out, shift_operand_out, imm_out
    );
endinterface

// File: rtl/register_file_bypass.sv
// Register file with two combinational read ports and same-cycle write-through; writes land on the clock edge.
// No flow control: the write is unconditional whenever we is high.
module register_file_bypass #(
    parameter int REG_CNT = 16,
    parameter int N       = 32,
    parameter int RA_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [N-1:0]    wdata,
    input  logic [RA_W-1:0] raddr_a,
    input  logic [RA_W-1:0] raddr_b,
    output logic [N-1:0]    rdata_a,
    output logic [N-1:0]    rdata_b
);

    logic [N-1:0] regs [REG_CNT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-through lets a WB result reach the instruction decoding in the same cycle.
    always_comb begin
        rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
        rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: decode, register read, condition check, hazard detection; ID/EX register gives 1-cycle latency.
// hazard_out stalls IF and IF/ID combinationally; freeze holds ID/EX, flush and hazards insert a bubble.
module id_stage_pipelined
    import arm_pkg::*;
#(
    parameter int N       = 32,
    parameter int REG_CNT = 16,
    parameter int RA_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    id_stage_pipelined_if.slave  bus
);

    logic [3:0]      cond;
    logic [3:0]      opcode;
    logic [1:0]      mode;
    logic            imm_bit;
    logic            s_bit;
    logic [RA_W-1:0] rn;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rm;
    logic [RA_W-1:0] src2;
    logic            is_str;
    logic            two_src;
    logic            rn_used;
    logic            cond_ok;
    logic            data_hazard;
    logic            status_hazard;
    logic            hazard;
    logic [N-1:0]    val_rn;
    logic [N-1:0]    val_rm;
    ctrl_t           ctrl;

    assign cond    = bus.instr_in[31:28];
    assign mode    = bus.instr_in[27:26];
    assign imm_bit = bus.instr_in[25];
    assign opcode  = bus.instr_in[24:21];
    assign s_bit   = bus.instr_in[20];
    assign rn      = RA_W'(bus.instr_in[19:16]);
    assign rd      = RA_W'(bus.instr_in[15:12]);
    assign rm      = RA_W'(bus.instr_in[3:0]);

    assign is_str  = (mode == MODE_MEM) && !s_bit;
    assign src2    = is_str ? rd : rm;
    assign two_src = ~imm_bit | is_str;
    assign rn_used = !((mode == MODE_BR) || (opcode == OP_MOV) || (opcode == OP_MVN));
    assign cond_ok = cond_pass(cond, bus.status_in);

    always_comb begin
        ctrl   = '0;
        ctrl.s = s_bit;
        case (mode)
            MODE_DP: begin
                case (opcode)
                    OP_MOV:  ctrl.exe_cmd = EXE_MOV;
                    OP_MVN:  ctrl.exe_cmd = EXE_MVN;
                    OP_ADD:  ctrl.exe_cmd = EXE_ADD;
                    OP_ADC:  ctrl.exe_cmd = EXE_ADC;
                    OP_SUB:  ctrl.exe_cmd = EXE_SUB;
                    OP_SBC:  ctrl.exe_cmd = EXE_SBC;
                    OP_AND:  ctrl.exe_cmd = EXE_AND;
                    OP_ORR:  ctrl.exe_cmd = EXE_ORR;
                    OP_EOR:  ctrl.exe_cmd = EXE_EOR;
                    OP_CMP:  ctrl.exe_cmd = EXE_SUB;
                    OP_TST:  ctrl.exe_cmd = EXE_AND;
                    default: ctrl.exe_cmd = EXE_NOP;
                endcase
                ctrl.wb_en = !((opcode == OP_CMP) || (opcode == OP_TST));
            end
            MODE_MEM: begin
                ctrl.exe_cmd  = EXE_ADD;
                ctrl.mem_r_en = s_bit;
                ctrl.mem_w_en = ~s_bit;
                ctrl.wb_en    = s_bit;
            end
            MODE_BR: begin
                ctrl.exe_cmd = EXE_NOP;
                ctrl.b       = 1'b1;
            end
            default: ctrl.exe_cmd = EXE_NOP;
        endcase
    end

    always_comb begin
        data_hazard = 1'b0;
        if (rn_used && ((bus.exe_wb_en_in && rn == bus.exe_dest_in) ||
                        (bus.mem_wb_en_in && rn == bus.mem_dest_in))) begin
            data_hazard = 1'b1;
        end
        if (two_src && ((bus.exe_wb_en_in && src2 == bus.exe_dest_in) ||
                        (bus.mem_wb_en_in && src2 == bus.mem_dest_in))) begin
            data_hazard = 1'b1;
        end
    end

    // An unconditional instruction does not care about flags still being produced in EXE.
    assign status_hazard  = bus.exe_s_in && (cond != COND_AL);
    assign hazard         = (data_hazard | status_hazard) & ~bus.flush_in;
    assign bus.hazard_out = hazard;

    register_file_bypass #(
        .REG_CNT (REG_CNT),
        .N       (N),
        .RA_W    (RA_W)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_en_in),
        .waddr   (bus.wb_dest_in),
        .wdata   (bus.wb_value_in),
        .raddr_a (rn),
        .raddr_b (src2),
        .rdata_a (val_rn),
        .rdata_b (val_rm)
    );

    logic [N-1:0]    pc_q;
    logic [N-1:0]    val_rn_q;
    logic [N-1:0]    val_rm_q;
    ctrl_t           ctrl_q;
    logic            i_q;
    logic            valid_q;
    logic [RA_W-1:0] dest_q;
    logic [RA_W-1:0] rn_q;
    logic [RA_W-1:0] src2_q;
    logic [11:0]     shift_q;
    logic [23:0]     imm_q;

    // Flush outranks freeze; a hazard only bubbles when ID/EX is not frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            ctrl_q   <= '0;
            i_q      <= 1'b0;
            valid_q  <= 1'b0;
            dest_q   <= '0;
            rn_q     <= '0;
            src2_q   <= '0;
            shift_q  <= '0;
            imm_q    <= '0;
        end else if (bus.flush_in) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.freeze_in) begin
            ctrl_q  <= ctrl_q;
            valid_q <= valid_q;
        end else if (hazard) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q     <= bus.pc_in;
            val_rn_q <= val_rn;
            val_rm_q <= val_rm;
            i_q      <= imm_bit;
            dest_q   <= rd;
            rn_q     <= rn;
            src2_q   <= src2;
            shift_q  <= bus.instr_in[11:0];
            imm_q    <= bus.instr_in[23:0];
            ctrl_q   <= cond_ok ? ctrl : '0;
            valid_q  <= cond_ok;
        end
    end

    assign bus.pc_out            = pc_q;
    assign bus.val_rn_out        = val_rn_q;
    assign bus.val_rm_out        = val_rm_q;
    assign bus.exe_cmd_out       = ctrl_q.exe_cmd;
    assign bus.s_out             = ctrl_q.s;
    assign bus.b_out             = ctrl_q.b;
    assign bus.mem_w_en_out      = ctrl_q.mem_w_en;
    assign bus.mem_r_en_out      = ctrl_q.mem_r_en;
    assign bus.wb_en_out         = ctrl_q.wb_en;
    assign bus.i_out             = i_q;
    assign bus.valid_out         = valid_q;
    assign bus.dest_out          = dest_q;
    assign bus.rn_out            = rn_q;
    assign bus.src2_out          = src2_q;
    assign bus.shift_operand_out = shift_q;
    assign bus.imm_out           = imm_q;

endmodule
